// File: rtl/alu_bitserial_seq_if.sv
// Bit-serial slice bus between the sequencer (master) and one 1-bit ALU slice (slave).
// The sequencer supplies operand bits and controls, and the slice returns its result bit and carry-out.
interface alu_bitserial_seq_if;
  logic       slice_a_o;
  logic       slice_b_o;
  logic       slice_c_o;
  logic       slice_invert_o;
  logic       slice_less_o;
  logic       slice_lessunsigned_o;
  logic [2:0] slice_op_o;
  logic       slice_salida_i;
  logic       slice_c_i;

  modport master (
    output slice_a_o, slice_b_o, slice_c_o, slice_invert_o,
           slice_less_o, slice_lessunsigned_o, slice_op_o,
    input  slice_salida_i, slice_c_i
  );

  modport slave (
    input  slice_a_o, slice_b_o, slice_c_o, slice_invert_o,
           slice_less_o, slice_lessunsigned_o, slice_op_o,
    output slice_salida_i, slice_c_i
  );
endinterface

// File: rtl/alu_bitserial_seq.sv
// Sequencer that runs a WIDTH-bit operation through one external 1-bit ALU slice, LSB first.
// Comparisons take a second pass that shifts the less/lessunsigned flag into bit 0.
module alu_bitserial_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [2:0]           operacion_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [WIDTH-1:0]     resultado_o,
  output logic                 carry_o,
  output logic                 zero_o,
  alu_bitserial_seq_if.master  slice_if
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_SET  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d, res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             lts_q, lts_d, ltu_q, ltu_d;
  logic             cout_q, cout_d, zero_q, zero_d;

  logic             accept, last_bit, is_cmp, is_sub, sub_in;
  logic [WIDTH-1:0] sh_next;

  assign accept   = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign is_cmp   = (op_q == 3'b101) || (op_q == 3'b110);
  assign is_sub   = (op_q == 3'b100) || is_cmp;
  assign sub_in   = (operacion_i == 3'b100) || (operacion_i == 3'b101) ||
                    (operacion_i == 3'b110);
  assign sh_next  = {slice_if.slice_salida_i, sh_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    res_d   = res_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    lts_d   = lts_q;
    ltu_d   = ltu_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    case (state_q)
      S_RUN: begin
        carry_d = slice_if.slice_c_i;
        sh_d    = sh_next;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          cnt_d = '0;
          if (is_cmp) begin
            // Operand MSBs are still at bit 0 here; sign overflow decides via the A sign
            lts_d   = (a_q[0] != b_q[0]) ? a_q[0] : slice_if.slice_salida_i;
            ltu_d   = ~slice_if.slice_c_i;
            state_d = S_SET;
          end else begin
            res_d   = sh_next;
            zero_d  = (sh_next == '0);
            cout_d  = ((op_q == 3'b000) || (op_q == 3'b100)) ? slice_if.slice_c_i : 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_SET: begin
        sh_d  = sh_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          cnt_d   = '0;
          res_d   = sh_next;
          zero_d  = (sh_next == '0);
          cout_d  = carry_q;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          a_d     = a_i;
          b_d     = b_i;
          op_d    = operacion_i;
          cnt_d   = '0;
          carry_d = sub_in;
          state_d = S_RUN;
        end
      end
    endcase
  end

  // The slice sees live operand bits only in RUN; SET only carries the comparison flag.
  always_comb begin
    slice_if.slice_a_o            = 1'b0;
    slice_if.slice_b_o            = 1'b0;
    slice_if.slice_c_o            = 1'b0;
    slice_if.slice_invert_o       = 1'b0;
    slice_if.slice_less_o         = 1'b0;
    slice_if.slice_lessunsigned_o = 1'b0;
    slice_if.slice_op_o           = 3'b000;
    if (state_q == S_RUN) begin
      slice_if.slice_a_o      = a_q[0];
      slice_if.slice_b_o      = b_q[0];
      slice_if.slice_c_o      = carry_q;
      slice_if.slice_invert_o = is_sub;
      slice_if.slice_op_o     = is_cmp ? 3'b100 : op_q;
    end else if (state_q == S_SET) begin
      slice_if.slice_op_o           = op_q;
      slice_if.slice_less_o         = (cnt_q == '0) && lts_q;
      slice_if.slice_lessunsigned_o = (cnt_q == '0) && ltu_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      res_q   <= '0;
      op_q    <= 3'b000;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      lts_q   <= 1'b0;
      ltu_q   <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      lts_q   <= lts_d;
      ltu_q   <= ltu_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
    end
  end

  assign busy_o      = (state_q == S_RUN) || (state_q == S_SET);
  assign done_o      = (state_q == S_DONE);
  assign resultado_o = res_q;
  assign carry_o     = cout_q;
  assign zero_o      = zero_q;

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Directed bench for alu_bitserial_seq at WIDTH=8 with a behavioural 1-bit ALU slice attached.
module tb_alu_bitserial_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = 3'b000;
  logic         busy, done, carry, zero;
  logic [W-1:0] res;

  int tests_run = 0;
  int tests_failed = 0;

  alu_bitserial_seq_if sif ();

  alu_bitserial_seq #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .a_i         (a),
    .b_i         (b),
    .operacion_i (op),
    .busy_o      (busy),
    .done_o      (done),
    .resultado_o (res),
    .carry_o     (carry),
    .zero_o      (zero),
    .slice_if    (sif)
  );

  always #5 clk = ~clk;

  // Classic 1-bit ALU slice: optional B inversion, full adder, logic ops, less pass-through
  logic bb;
  always_comb begin
    bb = sif.slice_b_o ^ sif.slice_invert_o;
    sif.slice_c_i = (sif.slice_a_o & bb) | (sif.slice_a_o & sif.slice_c_o) | (bb & sif.slice_c_o);
    case (sif.slice_op_o)
      3'b000, 3'b100: sif.slice_salida_i = sif.slice_a_o ^ bb ^ sif.slice_c_o;
      3'b001:         sif.slice_salida_i = sif.slice_a_o & bb;
      3'b010:         sif.slice_salida_i = sif.slice_a_o | bb;
      3'b011:         sif.slice_salida_i = sif.slice_a_o ^ bb;
      3'b101:         sif.slice_salida_i = sif.slice_less_o;
      3'b110:         sif.slice_salida_i = sif.slice_lessunsigned_o;
      default:        sif.slice_salida_i = 1'b0;
    endcase
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Assert start for one cycle; returns in cycle 1 of the new pass
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] ov);
    a = av;
    b = bv;
    op = ov;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int busy_cnt, output int less_first,
                           output int less_cnt);
    cyc = 1;
    busy_cnt = 0;
    less_first = -1;
    less_cnt = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (sif.slice_less_o === 1'b1) begin
        if (less_first < 0) less_first = cyc;
        less_cnt++;
      end
      next_cycle();
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    logic [8:0] sl;
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    sl = {sif.slice_a_o, sif.slice_b_o, sif.slice_c_o, sif.slice_invert_o,
          sif.slice_less_o, sif.slice_lessunsigned_o, sif.slice_op_o};
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done got %b want 0", done); end
    tests_run++; if (res !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_res got %h want 00", res); end
    tests_run++; if (carry !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_carry got %b want 0", carry); end
    tests_run++; if (zero !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_zero got %b want 0", zero); end
    tests_run++; if (sl !== 9'h000) begin tests_failed++; $display("[TB] FAIL reset_slice got %h want 000", sl); end
  endtask

  task automatic test_add();
    int cyc, bc, lf, lc;
    start_op(8'hFF, 8'h01, 3'b000);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL add_busy_c1 got %b want 1", busy); end
    wait_done(cyc, bc, lf, lc);
    tests_run++; if (cyc !== 9) begin tests_failed++; $display("[TB] FAIL add_done_cycle got %0d want 9", cyc); end
    tests_run++; if (bc !== 8) begin tests_failed++; $display("[TB] FAIL add_busy_cycles got %0d want 8", bc); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL add_busy_at_done got %b want 0", busy); end
    tests_run++; if (res !== 8'h00) begin tests_failed++; $display("[TB] FAIL add_res got %h want 00", res); end
    tests_run++; if (carry !== 1'b1) begin tests_failed++; $display("[TB] FAIL add_carry got %b want 1", carry); end
    tests_run++; if (zero !== 1'b1) begin tests_failed++; $display("[TB] FAIL add_zero got %b want 1", zero); end
    next_cycle();
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL add_done_pulse got %b want 0", done); end
    tests_run++; if (res !== 8'h00 || carry !== 1'b1) begin tests_failed++; $display("[TB] FAIL add_hold got %h/%b want 00/1", res, carry); end
  endtask

  task automatic test_sub();
    int cyc, bc, lf, lc;
    start_op(8'h05, 8'h07, 3'b100);
    tests_run++; if (sif.slice_c_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL sub_cin_bit0 got %b want 1", sif.slice_c_o); end
    tests_run++; if (sif.slice_invert_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL sub_invert_bit0 got %b want 1", sif.slice_invert_o); end
    tests_run++; if (sif.slice_op_o !== 3'b100) begin tests_failed++; $display("[TB] FAIL sub_op got %b want 100", sif.slice_op_o); end
    wait_done(cyc, bc, lf, lc);
    tests_run++; if (cyc !== 9) begin tests_failed++; $display("[TB] FAIL sub_done_cycle got %0d want 9", cyc); end
    tests_run++; if (res !== 8'hFE) begin tests_failed++; $display("[TB] FAIL sub_res got %h want fe", res); end
    tests_run++; if (carry !== 1'b0) begin tests_failed++; $display("[TB] FAIL sub_carry got %b want 0", carry); end
    tests_run++; if (zero !== 1'b0) begin tests_failed++; $display("[TB] FAIL sub_zero got %b want 0", zero); end
    next_cycle();
  endtask

  task automatic test_slt();
    int cyc, bc, lf, lc;
    start_op(8'hFE, 8'h01, 3'b101);
    tests_run++; if (sif.slice_op_o !== 3'b100) begin tests_failed++; $display("[TB] FAIL slt_run_op got %b want 100", sif.slice_op_o); end
    wait_done(cyc, bc, lf, lc);
    tests_run++; if (cyc !== 17) begin tests_failed++; $display("[TB] FAIL slt_done_cycle got %0d want 17", cyc); end
    tests_run++; if (bc !== 16) begin tests_failed++; $display("[TB] FAIL slt_busy_cycles got %0d want 16", bc); end
    tests_run++; if (lf !== 9 || lc !== 1) begin tests_failed++; $display("[TB] FAIL slt_less_window got first %0d count %0d want 9/1", lf, lc); end
    tests_run++; if (res !== 8'h01) begin tests_failed++; $display("[TB] FAIL slt_res got %h want 01", res); end
    tests_run++; if (zero !== 1'b0) begin tests_failed++; $display("[TB] FAIL slt_zero got %b want 0", zero); end
    next_cycle();
    start_op(8'hFE, 8'h01, 3'b110);
    wait_done(cyc, bc, lf, lc);
    tests_run++; if (cyc !== 17) begin tests_failed++; $display("[TB] FAIL sltu_done_cycle got %0d want 17", cyc); end
    tests_run++; if (res !== 8'h00) begin tests_failed++; $display("[TB] FAIL sltu_res got %h want 00", res); end
    tests_run++; if (zero !== 1'b1) begin tests_failed++; $display("[TB] FAIL sltu_zero got %b want 1", zero); end
    tests_run++; if (carry !== 1'b1) begin tests_failed++; $display("[TB] FAIL sltu_carry got %b want 1", carry); end
    next_cycle();
  endtask

  task automatic test_logic();
    logic [2:0] ops [4] = '{3'b001, 3'b010, 3'b011, 3'b111};
    logic [7:0] exps [4] = '{8'h30, 8'hFC, 8'hCC, 8'h00};
    logic       zexp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int cyc, bc, lf, lc;
    for (int i = 0; i < 4; i++) begin
      start_op(8'hF0, 8'h3C, ops[i]);
      wait_done(cyc, bc, lf, lc);
      tests_run++; if (cyc !== 9 || res !== exps[i]) begin tests_failed++; $display("[TB] FAIL logic_res op %b got %h at cycle %0d want %h at 9", ops[i], res, cyc, exps[i]); end
      tests_run++; if (carry !== 1'b0 || zero !== zexp[i]) begin tests_failed++; $display("[TB] FAIL logic_flags op %b got c%b z%b want c0 z%b", ops[i], carry, zero, zexp[i]); end
      next_cycle();
    end
  endtask

  task automatic test_busy_ignore();
    start_op(8'h12, 8'h34, 3'b000);
    a = 8'hFF;
    b = 8'hFF;
    op = 3'b011;
    start = 1'b1;
    for (int i = 0; i < 8; i++) next_cycle();
    start = 1'b0;
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL ignore_done got %b want 1", done); end
    tests_run++; if (res !== 8'h46) begin tests_failed++; $display("[TB] FAIL ignore_res got %h want 46", res); end
    next_cycle();
    tests_run++; if (busy !== 1'b0 || res !== 8'h46) begin tests_failed++; $display("[TB] FAIL ignore_idle got busy %b res %h want 0/46", busy, res); end
  endtask

  task automatic test_back_to_back();
    int cyc, bc, lf, lc;
    start_op(8'h01, 8'h02, 3'b000);
    wait_done(cyc, bc, lf, lc);
    tests_run++; if (res !== 8'h03) begin tests_failed++; $display("[TB] FAIL b2b_first got %h want 03", res); end
    start_op(8'hAA, 8'h0F, 3'b011);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_accept got busy %b want 1", busy); end
    wait_done(cyc, bc, lf, lc);
    tests_run++; if (cyc !== 9) begin tests_failed++; $display("[TB] FAIL b2b_done_cycle got %0d want 9", cyc); end
    tests_run++; if (res !== 8'hA5) begin tests_failed++; $display("[TB] FAIL b2b_second got %h want a5", res); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    int cyc, bc, lf, lc, dcount;
    logic [8:0] sl;
    start_op(8'h10, 8'h20, 3'b000);
    next_cycle();
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    sl = {sif.slice_a_o, sif.slice_b_o, sif.slice_c_o, sif.slice_invert_o,
          sif.slice_less_o, sif.slice_lessunsigned_o, sif.slice_op_o};
    tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_ctrl got busy %b done %b want 0/0", busy, done); end
    tests_run++; if (res !== 8'h00 || carry !== 1'b0 || zero !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_out got %h c%b z%b want 00 c0 z0", res, carry, zero); end
    tests_run++; if (sl !== 9'h000) begin tests_failed++; $display("[TB] FAIL rstmid_slice got %h want 000", sl); end
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || busy === 1'b1) dcount++;
      next_cycle();
    end
    tests_run++; if (dcount !== 0) begin tests_failed++; $display("[TB] FAIL rstmid_quiet got %0d active cycles want 0", dcount); end
    start_op(8'h10, 8'h20, 3'b000);
    wait_done(cyc, bc, lf, lc);
    tests_run++; if (cyc !== 9 || res !== 8'h30) begin tests_failed++; $display("[TB] FAIL rstmid_restart got %h at cycle %0d want 30 at 9", res, cyc); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_bitserial_seq.md
# alu_bitserial_seq

Bit-serial sequencer that drives one external 1-bit ALU slice to perform full WIDTH-bit operations over successive clock cycles. It accepts a start request with two operands and a 3-bit operation code, then presents one operand bit pair per cycle to the slice, LSB first. It feeds the slice's carry-out back into its carry-in and shifts the slice result into a result register. It is the controlling end of the slice interface and sits between the datapath register file and the slice in the area-reduced build of the core.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  request; accepted only in IDLE or DONE
- a_i  in  WIDTH  operand A, sampled on accept
- b_i  in  WIDTH  operand B, sampled on accept
- operacion_i  in  3  opcode, sampled on accept: 000 add, 001 and, 010 or, 011 xor, 100 sub, 101 slt, 110 sltu, 111 zero
- busy_o  out  1  high while a bit pass is running
- done_o  out  1  one-cycle pulse, result valid
- resultado_o  out  WIDTH  result, held until next accept
- carry_o  out  1  final carry of the add/sub pass; 0 for logic ops and 111
- zero_o  out  1  resultado_o == 0, updated with done_o
- slice_a_o  out  1  current A bit to slice
- slice_b_o  out  1  current B bit to slice
- slice_c_o  out  1  carry-in to slice
- slice_invert_o  out  1  slice B-inversion control
- slice_less_o  out  1  slice signed-less input
- slice_lessunsigned_o  out  1  slice unsigned-less input
- slice_op_o  out  3  slice operation code
- slice_salida_i  in  1  slice result bit
- slice_c_i  in  1  slice carry-out

## Operation
- States: IDLE, RUN, SET, DONE.
- On accept:
  - latch A and B into right-shift registers, plus the opcode
  - clear the bit counter
  - carry register = 1 for 100/101/110, else 0
  - go to RUN
- RUN, each cycle:
  - drive slice_a_o/slice_b_o from shift register bit 0 and slice_c_o from the carry register
  - slice_op_o = opcode, except 101/110, which drive 100
  - slice_invert_o = 1 for 100/101/110
  - capture slice_c_i into the carry register
  - shift slice_salida_i into the result MSB (result shifts right), shift the operands
- RUN exit: after WIDTH bits, 000–100 and 111 go to DONE; 101/110 go to SET.
- SET handling:
  - At RUN exit, record:
    - lt_s = (A_msb≠B_msb) ? A_msb : diff_msb
    - lt_u = ~final_carry
  - SET runs WIDTH cycles with slice_op_o = opcode.
  - slice_less_o = lt_s and slice_lessunsigned_o = lt_u on the bit-0 cycle only, 0 on all other cycles.
  - The result is shifted in as in RUN, then go to DONE.
- DONE, single cycle:
  - done_o = 1, zero_o registered
  - start_i accepted here as in IDLE, otherwise go to IDLE
- Slice outputs are 0 in IDLE and DONE.
- carry_o = final RUN carry for 000/100/101/110 and 0 otherwise; it is updated with done_o.
- start_i while busy_o = 1 is ignored; operand and opcode changes mid-pass have no effect.
- Reset mid-operation aborts the pass: return to IDLE with no done_o pulse.

## Timing
- Reset values:
  - state IDLE
  - busy_o, done_o, carry_o, zero_o, resultado_o = 0
  - all slice_* outputs 0
- Accept at edge of cycle 0. busy_o = 1 in cycles 1..W (W = WIDTH), or 1..2W for slt/sltu.
- Bit k is presented in cycle k+1 (RUN) or W+k+1 (SET).
- done_o = 1 in cycle W+1 (or 2W+1), with resultado_o, carry_o and zero_o valid in the same cycle and held afterwards.
- Latency is fixed and independent of operand values; back-to-back accept in the DONE cycle gives a throughput of one op per W+1 cycles.

## Test plan
- WIDTH=8, add 0xFF+0x01 → done_o in cycle 9, resultado_o=0x00, carry_o=1, zero_o=1; busy_o high cycles 1–8 exactly.
- sub 0x05−0x07 → resultado_o=0xFE, carry_o=0, zero_o=0; slice_c_o=1 and slice_invert_o=1 on the bit-0 cycle.
- slt 0xFE vs 0x01 → resultado_o=0x01 at cycle 17; sltu with the same operands → 0x00, zero_o=1; slice_less_o high only in cycle 9.
- and 0xF0,0x3C → 0x30; or → 0xFC; xor → 0xCC; op 111 → 0x00, carry_o=0, zero_o=1.
- start_i held high with new operands during busy → ignored, first result unchanged; start in the DONE cycle → second op done 9 cycles later.
- rst_i asserted in cycle 4 of an add → no done_o, all outputs 0 next cycle, state IDLE; a new start then completes normally.
